// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: state encoding, PC increment
// and small alignment helpers.
package pc_gen_pkg;

    // Sequencer states. BOOT holds the reset vector for one cycle before fetch starts.
    localparam logic [0:0] StBoot = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // Sequential fetch increment (one 32-bit instruction).
    localparam logic [31:0] PcIncr = 32'h4;

    // True when the two low address bits select a word boundary.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Push past capacity overwrites the oldest
// entry; push and pop in the same cycle replaces the top entry. Only the
// count and pointer are reset, the entry storage keeps its contents.
module pc_ras #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_o,
    output logic             valid_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];

    // ptr_q is the next write slot; the top entry lives one below it.
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] top_idx;
    logic [PtrW-1:0] wr_idx;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_en;
    logic            pop_eff;

    assign top_idx = ptr_q - PtrW'(1);
    assign top_o   = mem_q[top_idx];
    assign valid_o = (cnt_q != '0);

    // Next pointer/count and write slot from the push/pop request pair.
    always_comb begin
        pop_eff = pop_i && (cnt_q != '0);
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push_i && pop_eff) begin
            // Return followed by a call: top is replaced, depth unchanged.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PtrW'(1);
            if (cnt_q != CntW'(Depth)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_eff) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Pointer and occupancy, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential fetch, redirects, traps/mret with a saved
// EPC, misaligned-target rejection and a return-address stack for calls.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redir_target,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc,
    output logic            misalign,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misalign_q, misalign_d;

    logic            run;
    logic            target_ok;
    logic [XLEN-1:0] trap_target;
    logic            ras_push;
    logic            ras_pop;

    assign run         = (state_q == StRun);
    assign target_ok   = is_word_aligned(redir_target[1:0]);
    assign trap_target = trap_vec & ~XLEN'(3);

    // Wraps naturally modulo 2^XLEN.
    assign pc_plus4 = pc_q + XLEN'(PcIncr);

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign misalign = misalign_q;

    // Next PC by priority: trap > mret > redirect > stall > sequential.
    // In BOOT only a trap may move the PC.
    always_comb begin
        state_d    = StRun;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        if (trap) begin
            pc_d  = trap_target;
            epc_d = pc_q;
        end else if (run) begin
            if (mret) begin
                pc_d = epc_q;
            end else if (redirect) begin
                if (target_ok) begin
                    pc_d = redir_target;
                end else begin
                    misalign_d = 1'b1;
                end
            end else if (!stall) begin
                pc_d = pc_plus4;
            end
        end
    end

    // RAS requests: a call pushes only when its redirect is actually taken
    // and fetch is not stalled; a return pops unless stalled or trapping.
    always_comb begin
        ras_push = run && redirect && call && target_ok && !stall && !trap && !mret;
        ras_pop  = run && ret && !stall && !trap;
    end

    // Architectural PC state with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    pc_ras #(
        .Width (XLEN),
        .Depth (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_plus4),
        .top_o   (ras_top),
        .valid_o (ras_valid)
    );

endmodule
